// File: rtl/tdc_pkg.sv
// Shared types and helpers for the tapped-delay-line TDC blocks.
package tdc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_LAUNCH  = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } tdc_state_e;

    // Tap-count width: must hold every value 0..n_delay inclusive.
    function automatic int tdc_code_w(input int n_delay);
        return $clog2(n_delay) + 1;
    endfunction

endpackage

// File: rtl/tdc_therm_decode.sv
// Thermometer-code decoder: tap count plus bubble and saturation flags.
module tdc_therm_decode
    import tdc_pkg::*;
#(
    parameter int N_DELAY = 32,
    parameter int CODE_W  = tdc_code_w(N_DELAY)
) (
    input  logic [N_DELAY-1:0] code_i,
    output logic [CODE_W-1:0]  cnt_o,
    output logic               bubble_o,
    output logic               sat_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < N_DELAY; i++) begin
            cnt_o = cnt_o + CODE_W'(code_i[i]);
        end
    end

    // A clean code is 0..01..1; adding one then clears every set bit.
    assign bubble_o = (code_i & (code_i + N_DELAY'(1))) != '0;
    assign sat_o    = &code_i;

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer: runs 2^LOG_AVG clear/launch/settle/capture cycles
// on the delay line and returns sum/min/max of the decoded tap counts.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | line held clear, waiting for a request
// CLEAR   | one cycle of clear before each launch
// LAUNCH  | start edge into the delay line
// SETTLE  | start held SETTLE_CYC cycles while the edge propagates
// CAPTURE | code sampled and folded into the accumulators
// DONE    | result presented until consumed
module tdc_meas_ctrl
    import tdc_pkg::*;
#(
    parameter int N_DELAY    = 32,
    parameter int CODE_W     = tdc_code_w(N_DELAY),
    parameter int SETTLE_CYC = 2,
    parameter int LOG_AVG    = 2,
    parameter int SUM_W      = CODE_W + LOG_AVG
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    output logic               tdc_clear_o,
    output logic               tdc_start_o,
    input  logic [N_DELAY-1:0] tdc_code_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [SUM_W-1:0]   res_sum_o,
    output logic [CODE_W-1:0]  res_min_o,
    output logic [CODE_W-1:0]  res_max_o,
    output logic               res_bubble_o,
    output logic               res_sat_o
);

    localparam int SMP_W    = (LOG_AVG > 0) ? LOG_AVG : 1;
    localparam int SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int SET_LOAD = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;

    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << LOG_AVG) - 1);

    tdc_state_e          state_q, state_d;
    logic [SMP_W-1:0]    smp_cnt_q, smp_cnt_d;
    logic [SET_W-1:0]    set_cnt_q, set_cnt_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [CODE_W-1:0]   min_q, min_d;
    logic [CODE_W-1:0]   max_q, max_d;
    logic                bubble_q, bubble_d;
    logic                sat_q, sat_d;

    logic [CODE_W-1:0]   dec_cnt;
    logic                dec_bubble;
    logic                dec_sat;

    tdc_therm_decode #(
        .N_DELAY (N_DELAY),
        .CODE_W  (CODE_W)
    ) u_decode (
        .code_i   (tdc_code_i),
        .cnt_o    (dec_cnt),
        .bubble_o (dec_bubble),
        .sat_o    (dec_sat)
    );

    always_comb begin
        state_d     = state_q;
        smp_cnt_d   = smp_cnt_q;
        set_cnt_d   = set_cnt_q;
        sum_d       = sum_q;
        min_d       = min_q;
        max_d       = max_q;
        bubble_d    = bubble_q;
        sat_d       = sat_q;
        req_ready_o = 1'b0;
        tdc_clear_o = 1'b1;
        tdc_start_o = 1'b0;
        res_valid_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    sum_d     = '0;
                    min_d     = '1;
                    max_d     = '0;
                    bubble_d  = 1'b0;
                    sat_d     = 1'b0;
                    smp_cnt_d = '0;
                    state_d   = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                tdc_clear_o = 1'b0;
                tdc_start_o = 1'b1;
                set_cnt_d   = SET_W'(SET_LOAD);
                state_d     = (SETTLE_CYC > 0) ? ST_SETTLE : ST_CAPTURE;
            end
            ST_SETTLE: begin
                tdc_clear_o = 1'b0;
                tdc_start_o = 1'b1;
                if (set_cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    set_cnt_d = set_cnt_q - SET_W'(1);
                end
            end
            ST_CAPTURE: begin
                tdc_clear_o = 1'b0;
                tdc_start_o = 1'b1;
                sum_d       = sum_q + SUM_W'(dec_cnt);
                min_d       = (dec_cnt < min_q) ? dec_cnt : min_q;
                max_d       = (dec_cnt > max_q) ? dec_cnt : max_q;
                bubble_d    = bubble_q | dec_bubble;
                sat_d       = sat_q | dec_sat;
                if (smp_cnt_q == SMP_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    smp_cnt_d = smp_cnt_q + SMP_W'(1);
                    state_d   = ST_CLEAR;
                end
            end
            ST_DONE: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            smp_cnt_q <= '0;
            set_cnt_q <= '0;
            sum_q     <= '0;
            min_q     <= '1;
            max_q     <= '0;
            bubble_q  <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_cnt_q <= smp_cnt_d;
            set_cnt_q <= set_cnt_d;
            sum_q     <= sum_d;
            min_q     <= min_d;
            max_q     <= max_d;
            bubble_q  <= bubble_d;
            sat_q     <= sat_d;
        end
    end

    assign res_sum_o    = sum_q;
    assign res_min_o    = min_q;
    assign res_max_o    = max_q;
    assign res_bubble_o = bubble_q;
    assign res_sat_o    = sat_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl with default parameters.
module tb_tdc_meas_ctrl;

    localparam int N  = 32;
    localparam int CW = 6;
    localparam int SW = 8;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          tdc_clear;
    logic          tdc_start;
    logic [N-1:0]  tdc_code;
    logic          res_valid;
    logic          res_ready;
    logic [SW-1:0] res_sum;
    logic [CW-1:0] res_min;
    logic [CW-1:0] res_max;
    logic          res_bubble;
    logic          res_sat;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0][31:0] codes;
        logic [SW-1:0]    sum;
        logic [CW-1:0]    mn;
        logic [CW-1:0]    mx;
        logic             bub;
        logic             sat;
    } vec_t;

    vec_t vecs[6];

    tdc_meas_ctrl dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .tdc_clear_o  (tdc_clear),
        .tdc_start_o  (tdc_start),
        .tdc_code_i   (tdc_code),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_sum_o    (res_sum),
        .res_min_o    (res_min),
        .res_max_o    (res_max),
        .res_bubble_o (res_bubble),
        .res_sat_o    (res_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] c0, input logic [31:0] c1,
                                input logic [31:0] c2, input logic [31:0] c3,
                                input int sum, input int mn, input int mx,
                                input bit bub, input bit sat);
        vec_t v;
        v.codes[0] = c0;
        v.codes[1] = c1;
        v.codes[2] = c2;
        v.codes[3] = c3;
        v.sum      = SW'(sum);
        v.mn       = CW'(mn);
        v.mx       = CW'(mx);
        v.bub      = bub;
        v.sat      = sat;
        return v;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 1);
        chk({tag, "_clear"},     32'(tdc_clear), 1);
        chk({tag, "_start"},     32'(tdc_start), 0);
        chk({tag, "_res_valid"}, 32'(res_valid), 0);
    endtask

    // Called at a negedge in IDLE; ends at the negedge where DONE is expected.
    task automatic run_vec(input vec_t v, input int idx, input bit release_res);
        string t;
        t = $sformatf("v%0d", idx);
        req_valid = 1'b1;
        chk({t, "_req_ready"}, 32'(req_ready), 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 5; c++) begin
                tdc_code = v.codes[s];
                chk($sformatf("%s_s%0d_c%0d_clear", t, s, c), 32'(tdc_clear), (c == 0) ? 1 : 0);
                chk($sformatf("%s_s%0d_c%0d_start", t, s, c), 32'(tdc_start), (c == 0) ? 0 : 1);
                chk($sformatf("%s_s%0d_c%0d_valid", t, s, c), 32'(res_valid), 0);
                @(negedge clk);
            end
        end
        chk({t, "_res_valid"},  32'(res_valid), 1);
        chk({t, "_req_ready_done"}, 32'(req_ready), 0);
        chk({t, "_sum"},        32'(res_sum), 32'(v.sum));
        chk({t, "_min"},        32'(res_min), 32'(v.mn));
        chk({t, "_max"},        32'(res_max), 32'(v.mx));
        chk({t, "_bubble"},     32'(res_bubble), 32'(v.bub));
        chk({t, "_sat"},        32'(res_sat), 32'(v.sat));
        if (release_res) begin
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            check_idle({t, "_rel"});
            chk({t, "_sum_retained"}, 32'(res_sum), 32'(v.sum));
        end
    endtask

    initial begin
        vecs[0] = mk(32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF, 32, 8, 8, 0, 0);
        vecs[1] = mk(32'h0000_0001, 32'h0000_0003, 32'h0000_007F, 32'h0000_FFFF, 26, 1, 16, 0, 0);
        vecs[2] = mk(32'h0000_00F5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 102, 6, 32, 1, 1);
        vecs[3] = mk(32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        vecs[4] = mk(32'h8000_0000, 32'h0, 32'h0, 32'h0, 1, 0, 1, 1, 0);
        vecs[5] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 128, 32, 32, 0, 1);

        rst_n     = 1'b0;
        req_valid = 1'b1;
        res_ready = 1'b0;
        tdc_code  = '0;

        // Reset held with a request pending.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle($sformatf("rst%0d", i));
            chk($sformatf("rst%0d_sum", i), 32'(res_sum), 0);
            chk($sformatf("rst%0d_min", i), 32'(res_min), 32'h3F);
            chk($sformatf("rst%0d_max", i), 32'(res_max), 0);
        end
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check_idle("post_rst");

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i, 1'b1);
        end

        // Backpressure in DONE with requests pulsed.
        run_vec(vecs[1], 10, 1'b0);
        for (int i = 0; i < 10; i++) begin
            req_valid = (i % 2 == 0);
            @(negedge clk);
            chk($sformatf("bp%0d_valid", i),     32'(res_valid), 1);
            chk($sformatf("bp%0d_req_ready", i), 32'(req_ready), 0);
            chk($sformatf("bp%0d_sum", i),       32'(res_sum), 26);
            chk($sformatf("bp%0d_min", i),       32'(res_min), 1);
            chk($sformatf("bp%0d_max", i),       32'(res_max), 16);
            chk($sformatf("bp%0d_clear", i),     32'(tdc_clear), 1);
        end
        // res_ready and req_valid together: back to IDLE, request not taken.
        req_valid = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_idle("simul");
        // Request accepted on the following edge.
        @(negedge clk);
        req_valid = 1'b0;
        chk("simul_accept_req_ready", 32'(req_ready), 0);
        chk("simul_accept_clear",     32'(tdc_clear), 1);
        tdc_code = 32'h0000_0007;
        repeat (7) @(negedge clk);
        chk("mid_settle_start", 32'(tdc_start), 1);
        chk("mid_settle_clear", 32'(tdc_clear), 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("midrst");
        chk("midrst_sum",    32'(res_sum), 0);
        chk("midrst_min",    32'(res_min), 32'h3F);
        chk("midrst_max",    32'(res_max), 0);
        chk("midrst_bubble", 32'(res_bubble), 0);
        chk("midrst_sat",    32'(res_sat), 0);
        @(negedge clk);
        check_idle("midrst_hold");
        run_vec(vecs[0], 20, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
- Measurement sequencer for the tapped-delay-line TDC.
- On each accepted request it runs 2^LOG_AVG clear/launch/settle/capture cycles on the delay line.
- Each captured thermometer code is decoded to a tap count; the block accumulates sum, min and max across the run.
- Sits between the host/pin interface and the delay line, replacing direct pin drive of start/clear. Results go out on a valid/ready handshake.

Parameters:
- N_DELAY, 32, number of delay taps (width of the thermometer code).
- CODE_W, $clog2(N_DELAY)+1, tap-count width; holds 0..N_DELAY.
- SETTLE_CYC, 2, clk cycles start is held before capture; 0 is legal.
- LOG_AVG, 2, log2 of samples per result; 0 is legal.
- SUM_W, CODE_W+LOG_AVG, accumulator width; cannot overflow.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  measurement request.
- req_ready  out  1  high only in IDLE.
- tdc_clear  out  1  holds the delay line in reset.
- tdc_start  out  1  launch edge into the delay line.
- tdc_code  in  N_DELAY  thermometer code from the delay line.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_sum  out  SUM_W  sum of tap counts.
- res_min  out  CODE_W  minimum tap count.
- res_max  out  CODE_W  maximum tap count.
- res_bubble  out  1  sticky: some sample was not a clean thermometer code.
- res_sat  out  1  sticky: some sample had all taps set.

Behaviour:
- Reset (rst_n low at a rising edge) forces the following:
  - state=IDLE, req_ready=1, tdc_clear=1, tdc_start=0, res_valid=0.
  - res_sum=0, res_min=all ones, res_max=0, res_bubble=0, res_sat=0.
  - Sample counter=0, settle counter=0.
- Reset mid-operation aborts the run, with the reset values above visible after that edge. No partial result is emitted.
- FSM states are IDLE, CLEAR, LAUNCH, SETTLE, CAPTURE, DONE.
- IDLE:
  - Outputs: tdc_clear=1, tdc_start=0.
  - On req_valid&&req_ready, load the accumulator reset values, sample_cnt=0, and go to CLEAR.
- CLEAR (1 cycle): tdc_clear=1, tdc_start=0, then go to LAUNCH.
- LAUNCH (1 cycle): tdc_clear=0, tdc_start=1. Go to SETTLE if SETTLE_CYC>0, else to CAPTURE.
- SETTLE (SETTLE_CYC cycles): tdc_clear=0, tdc_start=1; counter-driven, then go to CAPTURE.
- CAPTURE (1 cycle): tdc_clear=0, tdc_start=1. On this edge, sample tdc_code and decode:
  - cnt = popcount(tdc_code).
  - bubble = (tdc_code & (tdc_code+1)) != 0.
  - sat = (tdc_code == all ones).
  - Update: sum+=cnt, min=min(min,cnt), max=max(max,cnt), bubble|=, sat|=.
  - If sample_cnt == 2^LOG_AVG-1, go to DONE; else increment sample_cnt and go to CLEAR.
- DONE:
  - Outputs: res_valid=1, tdc_clear=1, tdc_start=0.
  - All res_* outputs are stable while res_valid=1.
  - On res_ready, go to IDLE; res_valid drops on that edge.
  - res_* values are retained until the next request is accepted.
- Latency:
  - Each sample takes SETTLE_CYC+3 cycles.
  - res_valid rises exactly 2^LOG_AVG*(SETTLE_CYC+3) edges after the accepting edge (20 with defaults).
- req_valid is ignored outside IDLE; there is no queuing.
- res_ready in states other than DONE has no effect.
- Simultaneous res_ready with a new req_valid in DONE: the request is not accepted that cycle. It is accepted on the next cycle in IDLE.

Decomposition:
- Package tdc_pkg: state enum, and a CODE_W helper function (clog2+1).
- Sub-module tdc_therm_decode:
  - Combinational, N_DELAY in.
  - Outputs cnt[CODE_W], bubble, sat.
  - Reused by later TDC blocks.

Test Plan (defaults):
- Reset:
  - Stimulus: hold rst_n=0 for 3 cycles, with req_valid=1 throughout.
  - Response: req_ready=1, tdc_clear=1, tdc_start=0, res_valid=0, res_sum=0; no run starts until rst_n=1.
- Constant code:
  - Stimulus: tdc_code=32'h0000_00FF on every capture.
  - Response: res_valid exactly 20 cycles after acceptance; res_sum=32, min=max=8, bubble=0, sat=0.
  - Also check the start/clear pattern per sample: 1 cycle clear, then start high for 4 cycles.
- Varying codes:
  - Stimulus: captures 0x1, 0x3, 0x7F, 0xFFFF.
  - Response: res_sum=26, min=1, max=16, bubble=0.
- Bubble and saturation:
  - Stimulus: captures 0xF5, then 0xFFFFFFFF ×3.
  - Response: bubble=1 (0xF5 counts 6), sat=1, sum=102, min=6, max=32.
- Backpressure:
  - Stimulus: res_ready=0 for 10 cycles in DONE, with req_valid pulsed during that time.
  - Response: res_* held, req_ready=0, the request is not taken. res_ready=1 returns to IDLE in 1 cycle.
- Mid-run reset:
  - Stimulus: rst_n=0 for 1 cycle during SETTLE of sample 2.
  - Response: next cycle shows IDLE values; a new request yields a fresh 20-cycle result with no carry-over.
